// File: rtl/tsi_responder.sv
// Chip-side TSI responder: decodes read/write commands from the host word stream into one-word memory requests.
// Latency: every output is registered; each stream word, memory request and response costs at least one cycle.
// Backpressure: valid is held with stable data until ready; one memory request is outstanding at most.
//
// Ports:
//   clock, reset              - single clock, synchronous active-low reset
//   tsi_in_valid/ready/bits   - host->chip word stream (CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, write data)
//   tsi_out_valid/ready/bits  - chip->host word stream (read data, optional write-done word)
//   mem_req_*                 - one-word memory request (write flag, byte address, write data)
//   mem_resp_*                - memory response (read data; ignored for writes)
//   error                     - sticky flag, set when an unknown command word is consumed
// Build option: define TSI_WRITE_ACK_EN to send one 0x00000001 word to the host after each write command.
module tsi_responder #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tsi_in_valid,
  output logic              tsi_in_ready,
  input  logic [31:0]       tsi_in_bits,
  output logic              tsi_out_valid,
  input  logic              tsi_out_ready,
  output logic [31:0]       tsi_out_bits,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [31:0]       mem_resp_rdata,
  output logic              error
);

  typedef enum logic [3:0] {
    S_CMD,
    S_ADDR_LO,
    S_ADDR_HI,
    S_LEN_LO,
    S_LEN_HI,
    S_WDATA,
    S_WREQ,
    S_WACK,
    S_RREQ,
    S_RRESP,
    S_RSEND
`ifdef TSI_WRITE_ACK_EN
    , S_WDONE
`endif
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_count;
  logic              r_cmd;
  logic              r_error;

  logic              r_tsi_in_ready;
  logic              r_tsi_out_valid;
  logic [31:0]       r_tsi_out_bits;
  logic              r_mem_req_valid;
  logic [31:0]       r_mem_req_wdata;
  logic              r_mem_resp_ready;

  logic              w_tsi_in_ready;
  logic              w_tsi_out_valid;
  logic              w_mem_req_valid;
  logic              w_mem_resp_ready;

  logic              w_in_fire;
  logic              w_req_fire;
  logic              w_resp_fire;
  logic              w_out_fire;
  logic              w_cmd_ok;
  logic              w_last;

  // Handshakes use the registered ready/valid, so no input reaches an output combinationally.
  assign w_in_fire   = tsi_in_valid & r_tsi_in_ready;
  assign w_req_fire  = r_mem_req_valid & mem_req_ready;
  assign w_resp_fire = r_mem_resp_ready & mem_resp_valid;
  assign w_out_fire  = r_tsi_out_valid & tsi_out_ready;
  assign w_cmd_ok    = (tsi_in_bits == 32'd0) || (tsi_in_bits == 32'd1);
  // Termination by equality lets len = all-ones run to completion without overflow tricks.
  assign w_last      = (r_count == r_len);

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_CMD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CMD:     if (w_in_fire && w_cmd_ok) w_state_nxt = S_ADDR_LO;
      S_ADDR_LO: if (w_in_fire) w_state_nxt = S_ADDR_HI;
      S_ADDR_HI: if (w_in_fire) w_state_nxt = S_LEN_LO;
      S_LEN_LO:  if (w_in_fire) w_state_nxt = S_LEN_HI;
      S_LEN_HI:  if (w_in_fire) w_state_nxt = r_cmd ? S_WDATA : S_RREQ;
      S_WDATA:   if (w_in_fire) w_state_nxt = S_WREQ;
      S_WREQ:    if (w_req_fire) w_state_nxt = S_WACK;
      S_WACK: begin
        if (w_resp_fire) begin
`ifdef TSI_WRITE_ACK_EN
          w_state_nxt = w_last ? S_WDONE : S_WDATA;
`else
          w_state_nxt = w_last ? S_CMD : S_WDATA;
`endif
        end
      end
      S_RREQ:    if (w_req_fire) w_state_nxt = S_RRESP;
      S_RRESP:   if (w_resp_fire) w_state_nxt = S_RSEND;
      S_RSEND:   if (w_out_fire) w_state_nxt = w_last ? S_CMD : S_RREQ;
`ifdef TSI_WRITE_ACK_EN
      S_WDONE:   if (w_out_fire) w_state_nxt = S_CMD;
`endif
      default:   w_state_nxt = S_CMD;
    endcase
  end

  // Output decode of the upcoming state; the results are registered below so
  // every valid/ready pin comes straight from a flop.
  always_comb begin
    w_tsi_in_ready   = 1'b0;
    w_tsi_out_valid  = 1'b0;
    w_mem_req_valid  = 1'b0;
    w_mem_resp_ready = 1'b0;
    case (w_state_nxt)
      S_CMD, S_ADDR_LO, S_ADDR_HI,
      S_LEN_LO, S_LEN_HI, S_WDATA: w_tsi_in_ready   = 1'b1;
      S_WREQ, S_RREQ:              w_mem_req_valid  = 1'b1;
      S_WACK, S_RRESP:             w_mem_resp_ready = 1'b1;
      S_RSEND:                     w_tsi_out_valid  = 1'b1;
`ifdef TSI_WRITE_ACK_EN
      S_WDONE:                     w_tsi_out_valid  = 1'b1;
`endif
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_addr           <= '0;
      r_len            <= '0;
      r_count          <= '0;
      r_cmd            <= 1'b0;
      r_error          <= 1'b0;
      r_tsi_in_ready   <= 1'b0;
      r_tsi_out_valid  <= 1'b0;
      r_tsi_out_bits   <= '0;
      r_mem_req_valid  <= 1'b0;
      r_mem_req_wdata  <= '0;
      r_mem_resp_ready <= 1'b0;
    end else begin
      r_tsi_in_ready   <= w_tsi_in_ready;
      r_tsi_out_valid  <= w_tsi_out_valid;
      r_mem_req_valid  <= w_mem_req_valid;
      r_mem_resp_ready <= w_mem_resp_ready;

      case (r_state)
        S_CMD: begin
          if (w_in_fire) begin
            if (w_cmd_ok) r_cmd <= tsi_in_bits[0];
            else          r_error <= 1'b1;
          end
        end
        // The 64-bit wire address/length is assembled and truncated to the
        // internal width; the low word already sits in the register.
        S_ADDR_LO: if (w_in_fire) r_addr <= ADDR_W'(tsi_in_bits);
        S_ADDR_HI: if (w_in_fire) r_addr <= ADDR_W'({tsi_in_bits, 32'(r_addr)});
        S_LEN_LO:  if (w_in_fire) r_len  <= LEN_W'(tsi_in_bits);
        S_LEN_HI: begin
          if (w_in_fire) begin
            r_len   <= LEN_W'({tsi_in_bits, 32'(r_len)});
            r_count <= '0;
          end
        end
        S_WDATA:   if (w_in_fire) r_mem_req_wdata <= tsi_in_bits;
        S_WACK: begin
          if (w_resp_fire) begin
            r_addr  <= r_addr + ADDR_W'(4);
            r_count <= r_count + LEN_W'(1);
`ifdef TSI_WRITE_ACK_EN
            if (w_last) r_tsi_out_bits <= 32'd1;
`endif
          end
        end
        S_RRESP:   if (w_resp_fire) r_tsi_out_bits <= mem_resp_rdata;
        S_RSEND: begin
          if (w_out_fire) begin
            r_addr  <= r_addr + ADDR_W'(4);
            r_count <= r_count + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign tsi_in_ready   = r_tsi_in_ready;
  assign tsi_out_valid  = r_tsi_out_valid;
  assign tsi_out_bits   = r_tsi_out_bits;
  assign mem_req_valid  = r_mem_req_valid;
  assign mem_req_write  = r_cmd;
  assign mem_req_addr   = r_addr;
  assign mem_req_wdata  = r_mem_req_wdata;
  assign mem_resp_ready = r_mem_resp_ready;
  assign error          = r_error;

endmodule

// File: tb/tb_tsi_responder.sv
// Randomized scoreboard bench for tsi_responder.
// Stimulus pushes expected memory requests and host words; independent monitors pop and compare.
// Memory and host sinks apply random backpressure; directed cases cover the listed corner scenarios.
module tb_tsi_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        tsi_in_valid;
  logic        tsi_in_ready;
  logic [31:0] tsi_in_bits;
  logic        tsi_out_valid;
  logic        tsi_out_ready;
  logic [31:0] tsi_out_bits;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_rdata;
  logic        error;

  tsi_responder #(.ADDR_W(32), .LEN_W(32)) dut (
    .clock(clock), .reset(reset),
    .tsi_in_valid(tsi_in_valid), .tsi_in_ready(tsi_in_ready), .tsi_in_bits(tsi_in_bits),
    .tsi_out_valid(tsi_out_valid), .tsi_out_ready(tsi_out_ready), .tsi_out_bits(tsi_out_bits),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata),
    .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  int          n_total = 0;
  int          n_pass  = 0;
  req_t        exp_req[$];
  logic [31:0] exp_out[$];
  logic [31:0] ref_mem [logic [31:0]];   // reference model view of memory
  logic [31:0] dev_mem [logic [31:0]];   // storage behind the memory responder
  logic [31:0] wdat[$];                  // data words for the next write command
  bit          out_hold    = 1'b0;
  bit          mem_stall   = 1'b0;
  bit          stale_inject = 1'b0;

  function automatic logic [31:0] dflt(logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Memory responder: random request acceptance, random response latency.
  bit          m_busy = 1'b0;
  bit          m_rd;
  logic [31:0] m_addr;
  int          m_lat;
  always @(negedge clock) begin
    if (reset !== 1'b1) begin
      m_busy         = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = 32'd0;
    end else if (stale_inject) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'hBAD0_BAD0;
    end else begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (!m_busy && mem_req_valid) begin
        if ($urandom_range(0, 2) != 0) begin
          mem_req_ready = 1'b1;
          if (exp_req.size() == 0) begin
            n_total++;
            $display("FAIL mem_req_unexpected: got addr 0x%0h write %0d, expected none", mem_req_addr, mem_req_write);
          end else begin
            req_t e;
            e = exp_req.pop_front();
            chk("mem_req_write", 64'(mem_req_write), 64'(e.wr));
            chk("mem_req_addr", 64'(mem_req_addr), 64'(e.addr));
            if (e.wr) chk("mem_req_wdata", 64'(mem_req_wdata), 64'(e.data));
          end
          m_busy = 1'b1;
          m_rd   = !mem_req_write;
          m_addr = mem_req_addr;
          if (mem_req_write) dev_mem[mem_req_addr] = mem_req_wdata;
          m_lat  = $urandom_range(0, 3);
        end
      end else if (m_busy && mem_resp_ready && !mem_stall) begin
        if (m_lat == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = m_rd ? (dev_mem.exists(m_addr) ? dev_mem[m_addr] : dflt(m_addr)) : $urandom;
          m_busy = 1'b0;
        end else begin
          m_lat--;
        end
      end
    end
  end

  // Host-side sink: random ready, compares each accepted word with the scoreboard.
  always @(negedge clock) begin
    if (reset !== 1'b1) begin
      tsi_out_ready = 1'b0;
    end else begin
      tsi_out_ready = !out_hold && ($urandom_range(0, 3) != 0);
      if (tsi_out_ready && tsi_out_valid) begin
        if (exp_out.size() == 0) begin
          n_total++;
          $display("FAIL tsi_out_unexpected: got 0x%0h, expected no word", tsi_out_bits);
        end else begin
          chk("tsi_out_bits", 64'(tsi_out_bits), 64'(exp_out.pop_front()));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the word transferred.
  task automatic send_word(logic [31:0] w);
    int t = 0;
    if ($urandom_range(0, 3) == 0) @(negedge clock);
    tsi_in_valid = 1'b1;
    tsi_in_bits  = w;
    while (!tsi_in_ready) begin
      @(negedge clock);
      t++;
      if (t > 2000) begin
        $display("FAIL send_word_timeout: got tsi_in_ready 0 for 2000 cycles, expected 1");
        $fatal(1, "stream stuck");
      end
    end
    @(negedge clock);
    tsi_in_valid = 1'b0;
  endtask

  task automatic do_write(logic [31:0] a, int unsigned len, logic [31:0] hi_a, logic [31:0] hi_l);
    for (int unsigned i = 0; i <= len; i++) begin
      req_t e;
      e.wr = 1'b1; e.addr = a + 32'(4 * i); e.data = wdat[i];
      exp_req.push_back(e);
      ref_mem[e.addr] = e.data;
    end
`ifdef TSI_WRITE_ACK_EN
    exp_out.push_back(32'h0000_0001);
`endif
    send_word(32'd1); send_word(a); send_word(hi_a); send_word(32'(len)); send_word(hi_l);
    for (int unsigned i = 0; i <= len; i++) send_word(wdat[i]);
  endtask

  task automatic do_read(logic [31:0] a, int unsigned len, logic [31:0] hi_a, logic [31:0] hi_l);
    for (int unsigned i = 0; i <= len; i++) begin
      req_t e;
      e.wr = 1'b0; e.addr = a + 32'(4 * i); e.data = 32'd0;
      exp_req.push_back(e);
      exp_out.push_back(ref_rd(e.addr));
    end
    send_word(32'd0); send_word(a); send_word(hi_a); send_word(32'(len)); send_word(hi_l);
  endtask

  task automatic drain(string tag);
    int t = 0;
    while ((exp_req.size() != 0 || exp_out.size() != 0) && t < 3000) begin
      @(negedge clock);
      t++;
    end
    n_total++;
    if (exp_req.size() == 0 && exp_out.size() == 0) n_pass++;
    else $display("FAIL drain_%s: got %0d reqs / %0d words outstanding, expected 0", tag, exp_req.size(), exp_out.size());
    exp_req.delete();
    exp_out.delete();
    repeat (4) @(negedge clock);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_tsi_in_ready"},   64'(tsi_in_ready),   64'd0);
    chk({tag, "_tsi_out_valid"},  64'(tsi_out_valid),  64'd0);
    chk({tag, "_tsi_out_bits"},   64'(tsi_out_bits),   64'd0);
    chk({tag, "_mem_req_valid"},  64'(mem_req_valid),  64'd0);
    chk({tag, "_mem_req_write"},  64'(mem_req_write),  64'd0);
    chk({tag, "_mem_req_addr"},   64'(mem_req_addr),   64'd0);
    chk({tag, "_mem_req_wdata"},  64'(mem_req_wdata),  64'd0);
    chk({tag, "_mem_resp_ready"}, 64'(mem_resp_ready), 64'd0);
    chk({tag, "_error"},          64'(error),          64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] held;
    bit          seen;
    bit          bp_valid, bp_stable, bp_noreq;
    int          t;

    reset        = 1'b0;
    tsi_in_valid = 1'b0;
    tsi_in_bits  = 32'd0;
    for (int i = 0; i < 4; i++) begin
      ref_mem[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
      dev_mem[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
    end
    repeat (3) @(negedge clock);
    chk_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clock);
    chk("post_reset_in_ready", 64'(tsi_in_ready), 64'd1);

    // Single write
    wdat = '{32'hDEAD_BEEF};
    do_write(32'h8000_0000, 0, 32'd0, 32'd0);
    drain("single_write");

    // Burst read of the preloaded words
    do_read(32'h1000, 3, 32'd0, 32'd0);
    drain("burst_read");

    // Host backpressure during a read
    out_hold = 1'b1;
    do_read(32'h1000, 3, 32'd0, 32'd0);
    seen = 1'b0;
    t = 0;
    while (!seen && t < 500) begin
      @(negedge clock);
      t++;
      if (tsi_out_valid) seen = 1'b1;
    end
    chk("bp_word_presented", 64'(seen), 64'd1);
    held      = tsi_out_bits;
    bp_valid  = 1'b1;
    bp_stable = 1'b1;
    bp_noreq  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (!tsi_out_valid) bp_valid = 1'b0;
      if (tsi_out_bits !== held) bp_stable = 1'b0;
      if (mem_req_valid) bp_noreq = 1'b0;
    end
    chk("bp_valid_held", 64'(bp_valid), 64'd1);
    chk("bp_bits_stable", 64'(bp_stable), 64'd1);
    chk("bp_no_mem_req", 64'(bp_noreq), 64'd1);
    chk("bp_first_word", 64'(held), 64'hA0);
    out_hold = 1'b0;
    drain("backpressure");

    // Address wrap
    wdat = '{32'h1111_2222, 32'h3333_4444};
    do_write(32'hFFFF_FFFC, 1, 32'd0, 32'd0);
    drain("wrap_write");
    do_read(32'hFFFF_FFFC, 1, 32'd0, 32'd0);
    drain("wrap_read");

    // Bad command word
    chk("error_before_bad", 64'(error), 64'd0);
    send_word(32'd7);
    repeat (2) @(negedge clock);
    chk("error_after_bad", 64'(error), 64'd1);
    chk("in_ready_after_bad", 64'(tsi_in_ready), 64'd1);
    do_read(32'h1004, 1, 32'd0, 32'd0);
    drain("read_after_bad");
    chk("error_sticky", 64'(error), 64'd1);

    // Reset in the middle of a 4-word read, while waiting for the response
    mem_stall = 1'b1;
    begin
      req_t e;
      e.wr = 1'b0; e.addr = 32'h2000; e.data = 32'd0;
      exp_req.push_back(e);
    end
    send_word(32'd0); send_word(32'h2000); send_word(32'd0); send_word(32'd3); send_word(32'd0);
    t = 0;
    while (!mem_resp_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("midburst_in_rresp", 64'(mem_resp_ready), 64'd1);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_outputs("midburst_reset");
    reset        = 1'b1;
    mem_stall    = 1'b0;
    stale_inject = 1'b1;
    bp_noreq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (mem_resp_ready || tsi_out_valid || mem_req_valid) bp_noreq = 1'b0;
    end
    chk("stale_resp_ignored", 64'(bp_noreq), 64'd1);
    stale_inject = 1'b0;
    @(negedge clock);
    exp_req.delete();
    exp_out.delete();
    do_read(32'h1008, 1, 32'd0, 32'd0);
    drain("read_after_reset");

    // Randomized mix with junk high words (discarded at 32-bit widths)
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      int unsigned len;
      case ($urandom_range(0, 3))
        0:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        1:       a = 32'h1000 + 32'(4 * $urandom_range(0, 7));
        default: a = $urandom;
      endcase
      len = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) begin
        wdat.delete();
        for (int unsigned i = 0; i <= len; i++) wdat.push_back($urandom);
        do_write(a, len, $urandom, $urandom);
      end else begin
        do_read(a, len, $urandom, $urandom);
      end
      drain("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tsi_responder.md
Name: tsi_responder

Overview:
- Chip-side end of the 32-bit TSI serial link, the counterpart of the host-side simulation bridge.
- Consumes the host→chip word stream and decodes TSI read and write commands. Issues one-word memory requests on a simple valid/ready memory port.
- Streams read data back on the chip→host word stream.
- Sits between the TSI link pins and the chip's memory/bus adapter.

Parameters:
ADDR_W, 32, memory address width; wire address bits above ADDR_W are discarded
LEN_W, 32, internal length counter width; wire length bits above LEN_W are discarded

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-low reset (0 = reset)
tsi_in_valid  input  1  host→chip word valid
tsi_in_ready  output  1  host→chip word accepted
tsi_in_bits  input  32  host→chip word
tsi_out_valid  output  1  chip→host word valid
tsi_out_ready  input  1  chip→host word accepted
tsi_out_bits  output  32  chip→host word
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory request accepted
mem_req_write  output  1  1 = write, 0 = read
mem_req_addr  output  ADDR_W  word byte-address
mem_req_wdata  output  32  write data
mem_resp_valid  input  1  memory response valid
mem_resp_ready  output  1  memory response accepted
mem_resp_rdata  input  32  read data
error  output  1  sticky: unknown command seen

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. On reset low at a posedge:
  - state=CMD;
  - all valid/ready outputs 0;
  - tsi_out_bits, mem_req_addr, mem_req_wdata and mem_req_write are 0;
  - error=0;
  - internal addr, len and count are 0.
- Reset mid-operation abandons the command. Any in-flight memory response arriving after reset is ignored (mem_resp_ready stays 0 until state RRESP/WACK).
- Wire format, one word per handshake:
  - CMD: 0 = read, 1 = write;
  - ADDR_LO, ADDR_HI;
  - LEN_LO, LEN_HI, where len = number of data words − 1;
  - for a write, len+1 data words follow.
- Handshake rules:
  - A word transfers when valid&&ready at a posedge.
  - tsi_in_ready=1 only in states CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, WDATA.
  - All outputs are registered.
  - mem_req_* and tsi_out_* are held stable while valid is high and not yet accepted.
- State transitions:
  - CMD→ADDR_LO on accepting word 0 or 1; cmd is latched.
  - Any other CMD word: error←1, stay in CMD. The word is consumed and dropped.
  - ADDR_LO→ADDR_HI→LEN_LO→LEN_HI. LEN_HI moves to WDATA (write) or RREQ (read); count←0.
- Write path:
  - WDATA: accept a word, drive mem_req (write=1, addr, wdata) → WREQ.
  - WREQ: on mem_req_ready → WACK.
  - WACK: mem_resp_ready=1; on mem_resp_valid: addr←addr+4, count←count+1.
  - After the ack, go to CMD if count==len, else back to WDATA.
- Read path:
  - RREQ: mem_req (write=0, addr); on mem_req_ready → RRESP.
  - RRESP: mem_resp_ready=1; on mem_resp_valid, tsi_out_bits←rdata, tsi_out_valid←1 → RSEND.
  - RSEND: on tsi_out_ready, tsi_out_valid←0, addr+=4, count+=1. Go to CMD if the word just sent was number len, else RREQ.
- Arithmetic and width rules:
  - Address and count arithmetic is modulo 2^ADDR_W / 2^LEN_W; the address wraps silently.
  - Address low bits are used as given, with no alignment check.
  - len=0 means exactly one word.
  - len=2^LEN_W−1 is legal; termination uses equality, not overflow.
- Concurrency:
  - At most one memory request is outstanding.
  - Write responses carry no data; mem_resp_rdata is ignored in WACK.
- Simultaneous events: valid rising in the same cycle as the state change is accepted no earlier than the next cycle; there is no combinational ready path.

Optional Feature:
- Macro: TSI_WRITE_ACK_EN.
- Defined: after the final write ack, the block enters state WDONE and sends one word 0x00000001 on tsi_out. It returns to CMD on tsi_out_ready.
- Undefined: writes produce no chip→host traffic; WDONE does not exist.

Test Plan:
- Single write: in-stream 1, 0x80000000, 0, 0, 0, 0xDEADBEEF → one mem_req write addr 0x80000000 data 0xDEADBEEF; no tsi_out word (with TSI_WRITE_ACK_EN: one word 0x00000001).
- Burst read: 0, 0x1000, 0, 3, 0; memory returns 0xA0..0xA3 → reads at 0x1000, 0x1004, 0x1008, 0x100C in order; tsi_out emits 0xA0, 0xA1, 0xA2, 0xA3.
- Backpressure: hold tsi_out_ready=0 for 10 cycles during the read → tsi_out_valid stays 1 with bits stable; no new mem_req issued.
- Address wrap with ADDR_W=32: write len=1 at 0xFFFFFFFC → requests at 0xFFFFFFFC then 0x00000000.
- Bad command: word 7 → consumed, error=1, state returns to CMD; a following valid read completes normally and error stays 1.
- Reset mid-burst: assert reset low during RRESP of a 4-word read → all outputs 0; a stale mem_resp_valid is ignored; a new command is decoded correctly afterwards.
